// File: rtl/scariv_ldq_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// scariv_ldq_alloc_ctrl
//
// Allocation and retire pointer controller for the LSU load queue. It sits
// between dispatch and the array of load-queue entries.
//
// Dispatch side: a dispatch group of up to DISP_WIDTH loads is granted
// consecutive entries starting at the in-pointer. Each granted entry gets a
// strobe on o_entry_disp_load in the same cycle. Allocation is all-or-nothing.
//
// Retire side: a window of up to RETIRE_WIDTH occupied entries starting at the
// out-pointer is exposed on o_entry_outptr_valid. The out-pointer advances over
// the in-order run of finished entries inside that window. This frees their
// credits from the next cycle on.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_disp_valid          dispatch group presented this cycle
//   i_disp_load_num       loads in the group (0..DISP_WIDTH)
//   o_disp_ready          free entries >= i_disp_load_num (registered count only)
//   o_entry_disp_load     per-entry allocate strobe
//   i_entry_finish        per-entry finish (committed or dead)
//   o_entry_outptr_valid  per-entry retire window strobe
//   o_inptr, o_outptr     allocate / retire pointers, MSB is the wrap bit
//   o_count               occupied entries (0..LDQ_SIZE)
//   o_full, o_empty       derived from o_count
// ---------------------------------------------------------------------------
module scariv_ldq_alloc_ctrl #(
   parameter int LDQ_SIZE     = 16,
   parameter int DISP_WIDTH   = 4,
   parameter int RETIRE_WIDTH = 2
) (
   input  logic                             i_clk,
   input  logic                             i_reset_n,

   input  logic                             i_disp_valid,
   input  logic [$clog2(DISP_WIDTH+1)-1:0]  i_disp_load_num,
   output logic                             o_disp_ready,
   output logic [LDQ_SIZE-1:0]              o_entry_disp_load,

   input  logic [LDQ_SIZE-1:0]              i_entry_finish,
   output logic [LDQ_SIZE-1:0]              o_entry_outptr_valid,

   output logic [$clog2(LDQ_SIZE):0]        o_inptr,
   output logic [$clog2(LDQ_SIZE):0]        o_outptr,
   output logic [$clog2(LDQ_SIZE):0]        o_count,
   output logic                             o_full,
   output logic                             o_empty
);

   localparam int IW = $clog2(LDQ_SIZE);          // entry index width
   localparam int PW = IW + 1;                    // pointer / count width
   localparam int CW = PW + 1;                    // headroom for overflow check
   localparam int NW = $clog2(DISP_WIDTH + 1);
   localparam int RW = $clog2(RETIRE_WIDTH + 1);

   logic [PW-1:0] inptr_q;
   logic [PW-1:0] outptr_q;
   logic [PW-1:0] count_q;
   logic [PW-1:0] free;

   logic          alloc_fire;
   logic [NW-1:0] n_alloc;
   logic [RW-1:0] n_retire;
   logic          run;
   logic [CW-1:0] count_next;

   // -------------------------------------------------------------------------
   // Dispatch side
   // -------------------------------------------------------------------------
   // Credits come from the registered count only, so a retire in this cycle
   // does not help a dispatch in the same cycle.
   assign free         = PW'(LDQ_SIZE) - count_q;
   assign o_disp_ready = (int'(free) >= int'(i_disp_load_num));

   // Gating with reset keeps the strobes quiet while reset is held, even if
   // dispatch keeps presenting a group.
   assign alloc_fire = i_reset_n & i_disp_valid & o_disp_ready;
   assign n_alloc    = alloc_fire ? i_disp_load_num : '0;

   // The index sum is IW bits wide, so it wraps modulo LDQ_SIZE by itself.
   always_comb begin
      o_entry_disp_load = '0;
      for (int k = 0; k < DISP_WIDTH; k++) begin
         if (k < int'(n_alloc)) begin
            o_entry_disp_load[inptr_q[IW-1:0] + IW'(k)] = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Retire side
   // -------------------------------------------------------------------------
   always_comb begin
      o_entry_outptr_valid = '0;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         if (k < int'(count_q)) begin
            o_entry_outptr_valid[outptr_q[IW-1:0] + IW'(k)] = 1'b1;
         end
      end
   end

   // Retire the in-order run of finished entries. The first unfinished or
   // unoccupied slot ends the run, even if later slots report finish.
   always_comb begin
      n_retire = '0;
      run      = 1'b1;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         if (run &&
             o_entry_outptr_valid[outptr_q[IW-1:0] + IW'(k)] &&
             i_entry_finish[outptr_q[IW-1:0] + IW'(k)]) begin
            n_retire = n_retire + RW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   // The extra MSB lets the overflow check see count values above LDQ_SIZE.
   assign count_next = {1'b0, count_q} + CW'(n_alloc) - CW'(n_retire);

   // Power-of-two queue: carrying out of the index bits flips the wrap bit.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         inptr_q  <= '0;
         outptr_q <= '0;
         count_q  <= '0;
      end else begin
         inptr_q  <= inptr_q  + PW'(n_alloc);
         outptr_q <= outptr_q + PW'(n_retire);
         count_q  <= count_next[PW-1:0];
      end
   end

   assign o_inptr  = inptr_q;
   assign o_outptr = outptr_q;
   assign o_count  = count_q;
   assign o_full   = (count_q == PW'(LDQ_SIZE));
   assign o_empty  = (count_q == '0);

   // -------------------------------------------------------------------------
   // Consistency checks
   // -------------------------------------------------------------------------
   always @(posedge i_clk) begin
      if (i_reset_n) begin
         assert (count_next <= CW'(LDQ_SIZE))
            else $fatal(1, "ldq count would exceed LDQ_SIZE");
         assert ((i_entry_finish & ~o_entry_outptr_valid) == '0)
            else $fatal(1, "ldq finish reported outside the retire window");
         assert (o_full == ((inptr_q[IW-1:0] == outptr_q[IW-1:0]) &&
                            (inptr_q[IW] != outptr_q[IW])))
            else $fatal(1, "ldq full disagrees with pointers");
         assert (o_empty == (inptr_q == outptr_q))
            else $fatal(1, "ldq empty disagrees with pointers");
      end
   end

endmodule

// File: tb/tb_scariv_ldq_alloc_ctrl.sv
module tb_scariv_ldq_alloc_ctrl;

   logic        clk;
   logic        rst_n;
   logic        disp_valid;
   logic [2:0]  load_num;
   logic        disp_ready;
   logic [15:0] disp_load;
   logic [15:0] finish;
   logic [15:0] outptr_valid;
   logic [4:0]  inptr;
   logic [4:0]  outptr;
   logic [4:0]  count;
   logic        full;
   logic        empty;

   int vectors;
   int miscompares;

   scariv_ldq_alloc_ctrl #(
      .LDQ_SIZE     (16),
      .DISP_WIDTH   (4),
      .RETIRE_WIDTH (2)
   ) dut (
      .i_clk                (clk),
      .i_reset_n            (rst_n),
      .i_disp_valid         (disp_valid),
      .i_disp_load_num      (load_num),
      .o_disp_ready         (disp_ready),
      .o_entry_disp_load    (disp_load),
      .i_entry_finish       (finish),
      .o_entry_outptr_valid (outptr_valid),
      .o_inptr              (inptr),
      .o_outptr             (outptr),
      .o_count              (count),
      .o_full               (full),
      .o_empty              (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
         else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      disp_valid  = 1'b0;
      load_num    = 3'd0;
      finish      = 16'h0000;
      #2;

      // reset values
      chk("rst_count",    32'(count),        32'h0);
      chk("rst_inptr",    32'(inptr),        32'h0);
      chk("rst_outptr",   32'(outptr),       32'h0);
      chk("rst_full",     32'(full),         32'h0);
      chk("rst_empty",    32'(empty),        32'h1);
      chk("rst_ready",    32'(disp_ready),   32'h1);
      chk("rst_dload",    32'(disp_load),    32'h0);
      chk("rst_window",   32'(outptr_valid), 32'h0);
      tick();
      rst_n = 1'b1;

      // first dispatch of 3, zero-latency strobes
      disp_valid = 1'b1; load_num = 3'd3; #1;
      chk("a_dload3",     32'(disp_load),    32'h0007);
      chk("a_ready3",     32'(disp_ready),   32'h1);
      tick();
      disp_valid = 1'b0; load_num = 3'd0; #1;
      chk("a_inptr",      32'(inptr),        32'h3);
      chk("a_count",      32'(count),        32'h3);
      chk("a_window",     32'(outptr_valid), 32'h0003);
      chk("a_empty",      32'(empty),        32'h0);

      // valid group of zero loads does nothing
      disp_valid = 1'b1; load_num = 3'd0; #1;
      chk("a_dload0",     32'(disp_load),    32'h0);
      tick();
      disp_valid = 1'b0;
      chk("a_inptr_n0",   32'(inptr),        32'h3);

      // gap at outptr stops the run
      finish = 16'h0002;
      tick();
      chk("gap_outptr",   32'(outptr),       32'h0);
      chk("gap_count",    32'(count),        32'h3);
      finish = 16'h0003;
      tick();
      finish = 16'h0000; #1;
      chk("ret2_outptr",  32'(outptr),       32'h2);
      chk("ret2_count",   32'(count),        32'h1);
      chk("ret2_window",  32'(outptr_valid), 32'h0004);

      // fill to 14
      disp_valid = 1'b1; load_num = 3'd4;
      tick(); tick(); tick();
      load_num = 3'd1;
      tick();
      disp_valid = 1'b0; load_num = 3'd0;
      chk("fill_count",   32'(count),        32'd14);
      chk("fill_inptr",   32'(inptr),        32'h10);

      // not enough room for 3
      disp_valid = 1'b1; load_num = 3'd3; #1;
      chk("nr_ready",     32'(disp_ready),   32'h0);
      chk("nr_dload",     32'(disp_load),    32'h0);
      tick();
      chk("nr_count",     32'(count),        32'd14);

      // exactly enough for 2
      load_num = 3'd2; #1;
      chk("fit_ready",    32'(disp_ready),   32'h1);
      chk("fit_dload",    32'(disp_load),    32'h0003);
      tick();
      disp_valid = 1'b0; load_num = 3'd0; #1;
      chk("full_count",   32'(count),        32'd16);
      chk("full_full",    32'(full),         32'h1);
      chk("full_empty",   32'(empty),        32'h0);
      chk("full_inptr",   32'(inptr),        32'h12);
      load_num = 3'd1; #1;
      chk("full_ready1",  32'(disp_ready),   32'h0);
      load_num = 3'd0;

      // clean restart
      rst_n = 1'b0; #1;
      chk("rst2_count",   32'(count),        32'h0);
      chk("rst2_full",    32'(full),         32'h0);
      rst_n = 1'b1;

      // bring inptr to 14 then drain so outptr is 14
      disp_valid = 1'b1; load_num = 3'd4;
      tick(); tick(); tick();
      load_num = 3'd2;
      tick();
      disp_valid = 1'b0; load_num = 3'd0;
      chk("c_inptr14",    32'(inptr),        32'h0E);
      chk("c_count14",    32'(count),        32'd14);
      for (int j = 0; j < 7; j++) begin
         finish = 16'(32'h3 << (2 * j));
         tick();
      end
      finish = 16'h0000;
      chk("c_outptr14",   32'(outptr),       32'h0E);
      chk("c_empty",      32'(empty),        32'h1);

      // wrap on dispatch
      disp_valid = 1'b1; load_num = 3'd4; #1;
      chk("wrap_dload",   32'(disp_load),    32'hC003);
      tick();
      disp_valid = 1'b0; load_num = 3'd0; #1;
      chk("wrap_inptr",   32'(inptr),        32'h12);
      chk("wrap_count",   32'(count),        32'd4);
      chk("wrap_window",  32'(outptr_valid), 32'hC000);

      finish = 16'h4000;
      tick();
      finish = 16'h0000;
      chk("c_outptr15",   32'(outptr),       32'h0F);
      chk("c_count3",     32'(count),        32'd3);

      // refill to full with outptr at 15
      disp_valid = 1'b1; load_num = 3'd4;
      tick(); tick(); tick();
      load_num = 3'd1;
      tick();
      disp_valid = 1'b0; load_num = 3'd0;
      chk("c_full_count", 32'(count),        32'd16);
      chk("c_full",       32'(full),         32'h1);
      chk("c_full_inptr", 32'(inptr),        32'h1F);

      // full: retire across the wrap while dispatch of 1 is refused
      finish = 16'h8001; disp_valid = 1'b1; load_num = 3'd1; #1;
      chk("fr_ready",     32'(disp_ready),   32'h0);
      chk("fr_dload",     32'(disp_load),    32'h0);
      chk("fr_window",    32'(outptr_valid), 32'h8001);
      tick();
      disp_valid = 1'b0; load_num = 3'd0; finish = 16'h0000; #1;
      chk("fr_outptr",    32'(outptr),       32'h11);
      chk("fr_count",     32'(count),        32'd14);
      chk("fr_full",      32'(full),         32'h0);
      chk("fr_inptr",     32'(inptr),        32'h1F);

      // drain to 9
      finish = 16'h0006; tick();
      finish = 16'h0018; tick();
      finish = 16'h0020; tick();
      finish = 16'h0000;
      chk("d_count9",     32'(count),        32'd9);
      chk("d_outptr",     32'(outptr),       32'h16);

      // reset mid-operation with live strobes
      disp_valid = 1'b1; load_num = 3'd2; finish = 16'h0040; #1;
      chk("d_dload",      32'(disp_load),    32'h8001);
      chk("d_window",     32'(outptr_valid), 32'h00C0);
      rst_n = 1'b0; #1;
      chk("mr_count",     32'(count),        32'h0);
      chk("mr_empty",     32'(empty),        32'h1);
      chk("mr_full",      32'(full),         32'h0);
      chk("mr_dload",     32'(disp_load),    32'h0);
      chk("mr_window",    32'(outptr_valid), 32'h0);
      chk("mr_inptr",     32'(inptr),        32'h0);
      chk("mr_outptr",    32'(outptr),       32'h0);
      chk("mr_ready",     32'(disp_ready),   32'h1);
      disp_valid = 1'b0; load_num = 3'd0; finish = 16'h0000;
      tick();
      rst_n = 1'b1;
      disp_valid = 1'b1; load_num = 3'd1; #1;
      chk("post_dload",   32'(disp_load),    32'h0001);
      tick();
      disp_valid = 1'b0; load_num = 3'd0; #1;
      chk("post_count",   32'(count),        32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/scariv_ldq_alloc_ctrl.md
Name:
scariv_ldq_alloc_ctrl

Overview:
- Allocation/retire pointer controller for the LSU load queue.
- Sits between the dispatch stage and the array of load-queue entries.
- On dispatch, it grants consecutive entries from the in-pointer by pulsing each entry's dispatch-load strobe.
- On retire, it opens a window of out-pointer-valid strobes. It then advances the out-pointer over the run of entries that report finish in program order, and returns their credits to dispatch.

Parameters:
- LDQ_SIZE, 16, number of load-queue entries; must be a power of two and at least 4.
- DISP_WIDTH, 4, maximum loads allocated in one dispatch group.
- RETIRE_WIDTH, 2, maximum entries retired per cycle; must be 1 or more and no greater than LDQ_SIZE.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_disp_valid  in  1  dispatch group presented this cycle.
- i_disp_load_num  in  $clog2(DISP_WIDTH+1)  number of loads in the group (0..DISP_WIDTH).
- o_disp_ready  out  1  enough free entries for i_disp_load_num.
- o_entry_disp_load  out  LDQ_SIZE  per-entry allocate strobe (drives each entry's dispatch-load input).
- i_entry_finish  in  LDQ_SIZE  per-entry finish (committed or dead while out-pointer-valid).
- o_entry_outptr_valid  out  LDQ_SIZE  per-entry retire window strobe.
- o_inptr  out  $clog2(LDQ_SIZE)+1  allocate pointer; MSB is the wrap bit.
- o_outptr  out  $clog2(LDQ_SIZE)+1  retire pointer; MSB is the wrap bit.
- o_count  out  $clog2(LDQ_SIZE)+1  occupied entries.
- o_full  out  1  count == LDQ_SIZE.
- o_empty  out  1  count == 0.

Behaviour:
- Reset, asynchronous: inptr=0, outptr=0, count=0.
- Reset output values: o_full=0, o_empty=1, o_disp_ready=1, o_entry_disp_load=0, o_entry_outptr_valid=0.
- Free entries: free = LDQ_SIZE - count, computed from the registered count only.
  - A retire in the same cycle does not credit dispatch until the next cycle.
- Dispatch ready: o_disp_ready = (free >= i_disp_load_num). It is combinational and does not depend on i_disp_valid.
- Allocation fires when i_disp_valid & o_disp_ready, with n = i_disp_load_num.
  - o_entry_disp_load sets bits (inptr+k) mod LDQ_SIZE for k=0..n-1, in the same cycle (0-cycle latency).
  - inptr advances by n at the next clock edge; the wrap bit toggles when the index crosses LDQ_SIZE-1 to 0.
  - If n=0, or the group is not ready: no strobes and no pointer change.
  - Dispatch holds the group until ready; there is no partial allocation.
- Retire window: for k=0..RETIRE_WIDTH-1, bit (outptr+k) mod LDQ_SIZE of o_entry_outptr_valid is set when k < count.
  - This output is combinational from registered state.
- Retire count: r = the length of the contiguous run of set i_entry_finish bits starting at outptr, within the window.
  - A gap stops the run. Example: if the bit at outptr is clear and outptr+1 is set, then r=0.
  - Finish bits outside the window are ignored.
  - outptr advances by r at the next clock edge, with the same wrap rule as inptr.
- Count update: count_next = count + n_alloc - r, and is always in the range 0..LDQ_SIZE.
  - Simultaneous allocate and retire is allowed, including when the queue is full (retire only) or empty (allocate only).
- Flushes: no pointer rollback on branch or commit flush.
  - Flushed entries become dead, finish in order, and are retired through the normal window.
- Full/empty: o_full and o_empty are derived from count.
  - Cross-check: inptr==outptr with differing wrap bits must equal full; equal wrap bits must equal empty.
- Simulation-only checks:
  - A fatal error when count would exceed LDQ_SIZE.
  - A fatal error when a set i_entry_finish bit has its o_entry_outptr_valid bit clear.
- Reset mid-operation: all state clears immediately. Outputs go to their reset values within the same cycle.

Test Plan:
- Reset, then dispatch load_num=3 -> o_entry_disp_load=0x0007 in the same cycle; next cycle inptr=3, count=3, o_entry_outptr_valid=0x0003.
- With count=3 and finish=0x0002 (a gap at outptr) -> r=0, outptr stays 0; then finish=0x0003 -> outptr=2, count=1.
- Fill to count=14, then dispatch load_num=3 -> o_disp_ready=0 and no strobes; load_num=2 -> ready=1, count=16, o_full=1.
- Wrap: inptr=14 and dispatch 4 -> strobes 0xC003; inptr becomes 18 (wrap bit set, index 2).
- Full queue, outptr=15, finish bits at entries 15 and 0, and a simultaneous dispatch of 1 -> dispatch is rejected (ready uses old count); r=2, outptr index becomes 1 with the wrap bit toggled, count=14.
- Assert reset mid-stream with count=9 -> count=0, o_empty=1, and all strobes 0 immediately.
